// File: rtl/feedback_loop_window_stats.sv
// feedback_loop_window_stats
//   Collects consecutive accepted signed 8-bit samples into windows of N and
//   reports each window's minimum, maximum and exact signed sum through a
//   valid/ready result register.
//
// Ports
//   system1000       clock, all state updates on the rising edge
//   system1000_rstn  synchronous active-low reset
//   clear            discards the partial window (result register untouched)
//   in_valid/in_data/in_ready  sample input handshake (in_data signed)
//   res_valid/res_ready        result handshake
//   res_min/res_max/res_sum    window statistics (signed)
module feedback_loop_window_stats #(
  parameter  int N     = 8,
  localparam int SUM_W = 8 + $clog2(N)
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [7:0]       in_data,
  output logic                    in_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [7:0]       res_min,
  output logic signed [7:0]       res_max,
  output logic signed [SUM_W-1:0] res_sum
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           count;
  logic signed [7:0]       acc_min, acc_max;
  logic signed [SUM_W-1:0] acc_sum;

  logic accept, last, complete, xfer;
  logic signed [7:0]       new_min, new_max;
  logic signed [SUM_W-1:0] new_sum;

  assign res_valid = (state_q == FULL);
  assign last      = (count == CW'(N - 1));
  // Stall only when the closing sample would overwrite a result nobody takes.
  assign in_ready  = ~(res_valid & ~res_ready & last);
  assign accept    = in_valid & in_ready;
  assign xfer      = res_valid & res_ready;
  // A sample accepted while clear is high is discarded, so it cannot complete.
  assign complete  = accept & last & ~clear;

  assign new_min = (in_data < acc_min) ? in_data : acc_min;
  assign new_max = (in_data > acc_max) ? in_data : acc_max;
  assign new_sum = acc_sum + $signed({{(SUM_W-8){in_data[7]}}, in_data});

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (complete) state_d = FULL;
      FULL:  if (!complete && xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) state_q <= EMPTY;
    else                  state_q <= state_d;
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn || clear) begin
      count   <= '0;
      acc_min <= 8'sd127;
      acc_max <= -8'sd128;
      acc_sum <= '0;
    end else if (accept) begin
      if (last) begin
        count   <= '0;
        acc_min <= 8'sd127;
        acc_max <= -8'sd128;
        acc_sum <= '0;
      end else begin
        count   <= count + CW'(1);
        acc_min <= new_min;
        acc_max <= new_max;
        acc_sum <= new_sum;
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      res_min <= '0;
      res_max <= '0;
      res_sum <= '0;
    end else if (complete) begin
      res_min <= new_min;
      res_max <= new_max;
      res_sum <= new_sum;
    end
  end

endmodule

// File: tb/tb_feedback_loop_window_stats.sv
module tb_feedback_loop_window_stats;

  localparam int N  = 4;
  localparam int SW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstn, clear, in_valid, res_ready;
  logic signed [7:0]    in_data;
  logic                 in_ready, res_valid;
  logic signed [7:0]    res_min, res_max;
  logic signed [SW-1:0] res_sum;

  feedback_loop_window_stats #(.N(N)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_min         (res_min),
    .res_max         (res_max),
    .res_sum         (res_sum)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                v;
    logic signed [7:0] d;
    bit                rr;
    bit                clr;
    bit                erv;
    bit                chk;
    int                emin;
    int                emax;
    int                esum;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, int d, bit rr, bit clr, bit erv, bit chk,
                              int emin, int emax, int esum);
    vec_t t;
    t.v = v; t.d = 8'(d); t.rr = rr; t.clr = clr; t.erv = erv; t.chk = chk;
    t.emin = emin; t.emax = emax; t.esum = esum;
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string name, input bit erv, input bit chk,
                           input int emin, input int emax, input int esum);
    check({name, ".valid"}, {31'd0, res_valid}, {31'd0, erv});
    if (chk) begin
      check({name, ".min"}, res_min, emin);
      check({name, ".max"}, res_max, emax);
      check({name, ".sum"}, res_sum, esum);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int d, input bit rr, input bit clr);
    in_valid  = v;
    in_data   = 8'(d);
    res_ready = rr;
    clear     = clr;
  endtask

  task automatic sample(input int d, input bit rr);
    drive(1'b1, d, rr, 1'b0);
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check_res("reset", 1'b0, 1'b1, 0, 0, 0);
    check("reset.in_ready", {31'd0, in_ready}, 1);

    // basic window, then extremes, then gapped input
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, -2, 1, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0, 0, 0);
    add(1, -4, 1, 0, 1, 1, -4, 3, -2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 127, 1, 0, i == 3, i == 3, 127, 127, 508);
    for (int i = 0; i < 4; i++)
      add(1, -128, 1, 0, i == 3, i == 3, -128, -128, -512);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 10, 1, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) add(0, 99, 1, 0, 0, 0, 0, 0, 0);
    add(1, -10, 1, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) add(0, 99, 1, 0, 0, 0, 0, 0, 0);
    add(1, 20, 1, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) add(0, 99, 1, 0, 0, 0, 0, 0, 0);
    add(1, -20, 1, 0, 1, 1, -20, 20, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].clr);
      tick();
      check_res($sformatf("vec%0d", i), tbl[i].erv, tbl[i].chk,
                tbl[i].emin, tbl[i].emax, tbl[i].esum);
    end

    // backpressure: closing sample held until the pending result drains
    for (int i = 0; i < 4; i++) sample(5, 1'b0);
    check_res("bp.first", 1'b1, 1'b1, 5, 5, 20);
    sample(1, 1'b0);
    sample(2, 1'b0);
    sample(3, 1'b0);
    drive(1'b1, 4, 1'b0, 1'b0);
    #1;
    check("bp.stall_ready", {31'd0, in_ready}, 0);
    tick();
    check_res("bp.stable", 1'b1, 1'b1, 5, 5, 20);
    drive(1'b1, 4, 1'b1, 1'b0);
    #1;
    check("bp.release_ready", {31'd0, in_ready}, 1);
    tick();
    check_res("bp.second", 1'b1, 1'b1, 1, 4, 10);
    drive(1'b0, 0, 1'b1, 1'b0);
    tick();
    check_res("bp.drain", 1'b0, 1'b0, 0, 0, 0);

    // clear drops the partial window (and a sample accepted with it)
    for (int i = 0; i < 4; i++) sample(9, 1'b0);
    sample(7, 1'b0);
    sample(8, 1'b0);
    drive(1'b1, 50, 1'b0, 1'b1);
    tick();
    check_res("clr.pending", 1'b1, 1'b1, 9, 9, 36);
    drive(1'b0, 0, 1'b1, 1'b0);
    tick();
    check_res("clr.drain", 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) sample(1, 1'b1);
    check_res("clr.window", 1'b1, 1'b1, 1, 1, 4);
    drive(1'b0, 0, 1'b1, 1'b0);
    tick();

    // reset with a partial window and a pending result
    for (int i = 0; i < 4; i++) sample(3, 1'b0);
    sample(1, 1'b0);
    sample(1, 1'b0);
    sample(1, 1'b0);
    rstn = 1'b0;
    drive(1'b1, 6, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;
    check_res("rst.mid", 1'b0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample(2, 1'b1);
      check_res($sformatf("rst.partial%0d", i), 1'b0, 1'b0, 0, 0, 0);
    end
    sample(2, 1'b1);
    check_res("rst.window", 1'b1, 1'b1, 2, 2, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feedback_loop_window_stats.md
Name: feedback_loop_window_stats

Overview:
- Downstream consumer of the FeedbackLoop top entity's signed 8-bit output stream (out_o).
- Groups consecutive valid samples into fixed-length windows of N samples.
- For each window, reports the minimum, maximum and signed sum through a valid/ready result port.
- Feeds the testbench checker and scoreboard logic that decides pass/finish.

Parameters:
- N, 8, samples per window; legal range 2..256.
- SUM_W, 8+$clog2(N), signed sum width; derived, not overridden; wide enough that no window can overflow.

Ports:
- system1000  input  1  clock; all state updates on rising edge.
- system1000_rstn  input  1  synchronous active-low reset, sampled on rising edge of system1000.
- clear  input  1  synchronous discard of the partial window; the result register is unaffected.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  8  signed sample (out_o of the upstream stage).
- in_ready  output  1  block accepts in_data this cycle.
- res_valid  output  1  result register holds an unconsumed window result.
- res_ready  input  1  consumer takes the result this cycle.
- res_min  output  8  signed window minimum.
- res_max  output  8  signed window maximum.
- res_sum  output  SUM_W  signed window sum.

Behaviour:
- Reset (system1000_rstn=0 at an edge) applies regardless of other inputs:
  - count=0, acc_min=+127, acc_max=-128, acc_sum=0.
  - res_valid=0, res_min=0, res_max=0, res_sum=0.
  - Any partial window or pending result is lost.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Result transfer = res_valid & res_ready.
  - in_valid may drop between samples; gaps do not affect window contents.
- in_ready = ~(res_valid & ~res_ready & count==N-1):
  - Combinational on res_ready.
  - Stalls only when the last sample of a window would overwrite an unconsumed result.
- On an accept with count<N-1:
  - count+=1.
  - acc_min=min(acc_min,in_data), acc_max=max(acc_max,in_data).
  - acc_sum+=sign-extended in_data.
- On an accept with count==N-1 (window complete):
  - The result register loads the final min/max/sum, including the current sample.
  - res_valid=1 on the next cycle; latency from the last sample edge to res_valid is 1 cycle.
  - Accumulators return to their reset values and count=0 on the same edge.
- res_valid clears on a transfer unless a new window completes on the same edge; in that case res_valid stays 1 and the result register takes the new values.
- Result fields are stable while res_valid=1 and res_ready=0.
- clear=1 at an edge:
  - count and accumulators return to their reset values; any in_data accepted that cycle is discarded.
  - in_ready follows the normal rule during clear.
  - Result register and res_valid are unaffected; a simultaneous result transfer still completes.
- Arithmetic:
  - Comparisons are signed two's-complement.
  - Sum is exact: range [-128*N, 127*N] fits in SUM_W.
  - No saturation or wrap is required.
- Samples presented while in_ready=0 are not consumed; upstream holds them.
- FSM: two-state result register, EMPTY/FULL (mirrors res_valid).
  - EMPTY→FULL on window completion.
  - FULL→EMPTY on transfer without completion.
  - FULL→FULL on transfer plus completion, or on stall.
- Window counter wraps N-1→0 only on completion; it never advances without an accept.

Test Plan:
1. Reset, then N=4, res_ready=1, samples 1,-2,3,-4 on consecutive cycles → one cycle after the 4th accept: res_valid=1, res_min=-4, res_max=3, res_sum=-2 (10-bit); res_valid drops the next cycle.
2. N=4, extremes: four samples of 127 → sum=508, min=max=127; then four samples of -128 → sum=-512, min=max=-128; no overflow.
3. Backpressure, N=4, res_ready=0:
   - First window 5,5,5,5 → result pending.
   - Second window 1,2,3 accepted; 4th sample sees in_ready=0 and is held.
   - Raise res_ready → old result (sum 20) transfers, 4th sample accepted on the same edge.
   - Next cycle: res_valid=1, sum=10, min=1, max=4.
4. Gapped input: samples 10,-10,20,-20 with in_valid low for 3 cycles between each → res_sum=0, min=-20, max=20; count unaffected by gaps.
5. clear after two samples (7,8), then 1,1,1,1 → result sum=4, min=max=1; an already-pending result is unchanged by clear.
6. Reset asserted with 3 samples accumulated and a pending result → res_valid=0 and all result fields 0 next cycle; the following window 2,2,2,2 → sum=8.
